dp_ram_port_arbiter: RTL and testbench
======================================

// Module: dp_ram_port_arbiter
// PURPOSE
// - Shares one port of the byte-write dual-port block RAM between N OBI-style requesters.
// - Typical requesters: core data bus, debug module, program loader.
// - Round-robin grant; the granted request goes to the RAM port in the grant cycle.
// - Returns rvalid/rdata to the owning requester after the configured RAM read latency.
// - Sits between the interconnect and one RAM port; the other RAM port is untouched.
// PARAMETERS
// - NUM_REQ      2        number of requesters, 2..8
// - NB_COL       4        RAM byte columns; equals the be_i width
// - COL_WIDTH    8        bits per column; data width DW = NB_COL*COL_WIDTH
// - RAM_DEPTH    131072   RAM words; AW = $clog2(RAM_DEPTH)
// - RAM_LATENCY  1        1 = LOW_LATENCY RAM, 2 = HIGH_PERFORMANCE RAM (output register)
// - PRIO_REQ     -1       requester index that always wins when requesting; -1 = pure round-robin
// PORTS
// - clk_i       in   1              clock (shared with the RAM clock)
// - rst_ni      in   1              synchronous reset, active-low
// - req_i       in   NUM_REQ        per-requester request
// - addr_i      in   NUM_REQ x 32   byte address; word index = addr_i[AW+1:2]
// - we_i        in   NUM_REQ        1 = write, 0 = read
// - be_i        in   NUM_REQ x NB_COL  byte enables
// - wdata_i     in   NUM_REQ x DW   write data
// - gnt_o       out  NUM_REQ        grant, one-hot or zero, combinational from req_i
// - rvalid_o    out  NUM_REQ        response valid, one-hot or zero
// - rdata_o     out  NUM_REQ x DW   response data; ram_dout_i fanned out to all requesters
// - ram_en_o    out  1              RAM port enable
// - ram_we_o    out  NB_COL         RAM byte write enable
// - ram_addr_o  out  AW             RAM word address
// - ram_din_o   out  DW             RAM write data
// - ram_rst_o   out  1              RAM output-register reset = ~rst_ni
// - ram_regce_o out  1              RAM output-register enable
// - ram_dout_i  in   DW             RAM read data
// BEHAVIOUR
// - Clock and reset: one clock, clk_i. rst_ni is synchronous and active-low.
// - Reset values: gnt_o, rvalid_o, ram_en_o, ram_we_o, ram_regce_o = 0.
//   Round-robin pointer = 0. Response pipeline cleared.
// - Reset mid-operation: in-flight responses are dropped and no rvalid follows.
//   While rst_ni is low, gnt_o is held at 0.
// - Arbitration: single cycle, no wait states; the port accepts one request per cycle.
//   - If PRIO_REQ >= 0 and req_i[PRIO_REQ]=1, grant PRIO_REQ.
//   - Otherwise grant the first requesting index at or after ptr, circularly.
//   - The pointer register is ptr; after any grant to k, ptr <= (k+1) mod NUM_REQ.
//   - A grant to PRIO_REQ also advances ptr.
// - Grant cycle outputs:
//   - ram_en_o = |req_i; ram_addr_o = addr_i[k][AW+1:2]; upper address bits are ignored (aliasing).
//   - ram_we_o = we_i[k] ? be_i[k] : 0; ram_din_o = wdata_i[k].
//   - With no request: ram_en_o = 0, ram_we_o = 0; address and data are don't-care.
// - Response pipeline: shift register of {valid, index}, RAM_LATENCY stages deep.
//   - rvalid_o[k] = 1 exactly RAM_LATENCY cycles after gnt_o[k], for reads and for writes.
//   - Write response: rdata = the written bytes (write-first); unwritten bytes are the old contents.
// - ram_regce_o = stage-1 valid (only used when RAM_LATENCY=2); otherwise 0.
// - Back-to-back: grants every cycle are legal; responses return in grant order, one per cycle.
// - Requesters must accept rvalid unconditionally; there is no response back-pressure.
// - Requesters hold req_i/addr_i/etc. stable until gnt; a dropped req is not an error.
// - Same-cycle writes to one address from both RAM ports are outside this block
//   (the result is undefined at the RAM).
// STRUCTURE
// - Package dp_ram_arb_pkg: DW/AW helper functions, typedef ram_req_t {addr, we, be, wdata},
//   typedef rsp_tag_t {valid, idx}.
// - Sub-module dp_ram_rr_arb: parametric round-robin arbiter.
//   Inputs: req, prio index. Outputs: one-hot gnt, ptr register.
// - Top level holds: request mux, response tag pipeline, rvalid demux.
// TESTING
// - Reset: rst_ni low for 3 cycles with req_i=all ones -> gnt_o=0, rvalid_o=0, ram_en_o=0 throughout.
// - Single read: req0 read at addr 0x10 (RAM word 4 = 0xDEADBEEF) -> gnt0 in cycle 0,
//   rvalid0 with 0xDEADBEEF in cycle RAM_LATENCY.
// - Byte write: req1 write be=4'b0010, data 0x0000AA00, to word 4 -> rvalid1 rdata 0xDEADAAEF;
//   a following read of word 4 returns 0xDEADAAEF.
// - Round-robin: NUM_REQ=3, all requesting for 6 cycles -> grant order 0,1,2,0,1,2;
//   rvalid order matches, one per cycle.
// - Priority: PRIO_REQ=2, req0 and req2 both held high for 2 cycles -> grants 2,2;
//   after req2 drops -> grant 0.
// - Reset mid-flight: RAM_LATENCY=2, grant read then rst_ni low the next cycle
//   -> no rvalid ever issued for that read.

Source files
------------

// File: rtl/dp_ram_arb_pkg.sv
// Shared types and width helpers for the dual-port RAM port arbiter.
package dp_ram_arb_pkg;

    // Requester index field is sized for the largest supported requester count (8).
    localparam int unsigned MAX_REQ = 8;
    localparam int unsigned IDX_W   = 3;

    // One entry of the response tag pipeline.
    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } rsp_tag_t;

    function automatic int unsigned calc_dw(input int unsigned nb_col,
                                            input int unsigned col_width);
        return nb_col * col_width;
    endfunction

    function automatic int unsigned calc_aw(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // Width of a requester index; at least one bit.
    function automatic int unsigned calc_iw(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dp_ram_rr_arb.sv
// Single-cycle round-robin arbiter with an optional always-wins requester.
module dp_ram_rr_arb
    import dp_ram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 2,
    parameter int          PRIO_REQ = -1,
    localparam int unsigned PW      = calc_iw(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [PW-1:0]      idx_o,
    output logic [PW-1:0]      ptr_o
);

    localparam bit          HAS_PRIO = (PRIO_REQ >= 0);
    localparam int unsigned PRIO_IDX = HAS_PRIO ? PRIO_REQ : 0;

    logic [PW-1:0] ptr_q, ptr_d;
    logic          found;
    int unsigned   pos;

    // Pick the priority requester, else the first requester at or after ptr (circular).
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        pos   = 0;
        if (HAS_PRIO && req_i[PRIO_IDX]) begin
            gnt_o[PRIO_IDX] = 1'b1;
            idx_o           = PW'(PRIO_IDX);
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                pos = 32'(ptr_q) + i;
                if (pos >= NUM_REQ) pos = pos - NUM_REQ;
                // Constant-index scan keeps the select in range for non-power-of-2 counts.
                for (int unsigned k = 0; k < NUM_REQ; k++) begin
                    if (!found && (k == pos) && req_i[k]) begin
                        found    = 1'b1;
                        gnt_o[k] = 1'b1;
                        idx_o    = PW'(k);
                    end
                end
            end
        end
    end

    // Pointer moves past whichever index was granted, priority grants included.
    always_comb begin
        ptr_d = ptr_q;
        if (|gnt_o) begin
            ptr_d = (idx_o == PW'(NUM_REQ - 1)) ? '0 : idx_o + 1'b1;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) ptr_q <= '0;
        else         ptr_q <= ptr_d;
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/dp_ram_port_arbiter.sv
// Shares one byte-write block RAM port between NUM_REQ OBI-style requesters.
module dp_ram_port_arbiter
    import dp_ram_arb_pkg::*;
#(
    parameter int unsigned  NUM_REQ     = 2,
    parameter int unsigned  NB_COL      = 4,
    parameter int unsigned  COL_WIDTH   = 8,
    parameter int unsigned  RAM_DEPTH   = 131072,
    parameter int unsigned  RAM_LATENCY = 1,
    parameter int           PRIO_REQ    = -1,
    localparam int unsigned DW          = calc_dw(NB_COL, COL_WIDTH),
    localparam int unsigned AW          = calc_aw(RAM_DEPTH)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NUM_REQ-1:0]             req_i,
    input  logic [NUM_REQ-1:0][31:0]       addr_i,
    input  logic [NUM_REQ-1:0]             we_i,
    input  logic [NUM_REQ-1:0][NB_COL-1:0] be_i,
    input  logic [NUM_REQ-1:0][DW-1:0]     wdata_i,
    output logic [NUM_REQ-1:0]             gnt_o,
    output logic [NUM_REQ-1:0]             rvalid_o,
    output logic [NUM_REQ-1:0][DW-1:0]     rdata_o,
    output logic                           ram_en_o,
    output logic [NB_COL-1:0]              ram_we_o,
    output logic [AW-1:0]                  ram_addr_o,
    output logic [DW-1:0]                  ram_din_o,
    output logic                           ram_rst_o,
    output logic                           ram_regce_o,
    input  logic [DW-1:0]                  ram_dout_i
);

    localparam int unsigned PW = calc_iw(NUM_REQ);

    typedef struct packed {
        logic [31:0]       addr;
        logic              we;
        logic [NB_COL-1:0] be;
        logic [DW-1:0]     wdata;
    } ram_req_t;

    logic [NUM_REQ-1:0] req_m;
    logic [PW-1:0]      gnt_idx;
    logic [PW-1:0]      ptr;
    ram_req_t           sel;
    rsp_tag_t           pipe_q [RAM_LATENCY];
    rsp_tag_t           tag_out;
    logic               unused_bits;

    // No grants while reset is held.
    assign req_m = rst_ni ? req_i : '0;

    dp_ram_rr_arb #(
        .NUM_REQ  (NUM_REQ),
        .PRIO_REQ (PRIO_REQ)
    ) u_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (req_m),
        .gnt_o  (gnt_o),
        .idx_o  (gnt_idx),
        .ptr_o  (ptr)
    );

    // Route the granted requester onto the RAM port in the grant cycle.
    always_comb begin
        sel.addr   = addr_i[gnt_idx];
        sel.we     = we_i[gnt_idx];
        sel.be     = be_i[gnt_idx];
        sel.wdata  = wdata_i[gnt_idx];
        ram_en_o   = |req_m;
        ram_we_o   = (ram_en_o && sel.we) ? sel.be : '0;
        ram_addr_o = sel.addr[AW+1:2];
        ram_din_o  = sel.wdata;
    end

    // Upper address bits alias; the pointer is observable only for debug.
    assign unused_bits = ^{ptr, sel.addr[31:AW+2], sel.addr[1:0]};

    // Tag pipeline mirrors the RAM read latency; reset drops in-flight responses.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < RAM_LATENCY; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= '{valid: ram_en_o, idx: IDX_W'(gnt_idx)};
            for (int unsigned i = 1; i < RAM_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign tag_out     = pipe_q[RAM_LATENCY-1];
    assign ram_rst_o   = ~rst_ni;
    assign ram_regce_o = (RAM_LATENCY == 2) ? (rst_ni & pipe_q[0].valid) : 1'b0;

    // Demux the response to its owner; read data is fanned out to everyone.
    always_comb begin
        rvalid_o = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            rvalid_o[k] = rst_ni && tag_out.valid && (tag_out.idx == IDX_W'(k));
            rdata_o[k]  = ram_dout_i;
        end
    end

endmodule

// File: tb/tb_dp_ram_port_arbiter.sv
// Directed bench: a latency-1 round-robin instance (a) and a latency-2 instance with
// requester 2 as priority (b), each backed by a write-first byte-write RAM model.
module tb_dp_ram_port_arbiter;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             load;
    logic [2:0]       req;
    logic [2:0][31:0] addr;
    logic [2:0]       we;
    logic [2:0][3:0]  be;
    logic [2:0][31:0] wdata;

    logic [2:0]       gnt_a, rvalid_a, gnt_b, rvalid_b;
    logic [2:0][31:0] rdata_a, rdata_b;
    logic             en_a, en_b, rst_a, rst_b, regce_a, regce_b;
    logic [3:0]       rwe_a, rwe_b;
    logic [9:0]       raddr_a, raddr_b;
    logic [31:0]      din_a, din_b, dout_a, dout1_b, dout2_b;
    logic [31:0]      mem_a [1024];
    logic [31:0]      mem_b [1024];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dp_ram_port_arbiter #(
        .NUM_REQ(3), .NB_COL(4), .COL_WIDTH(8), .RAM_DEPTH(1024), .RAM_LATENCY(1), .PRIO_REQ(-1)
    ) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .addr_i(addr), .we_i(we), .be_i(be),
        .wdata_i(wdata), .gnt_o(gnt_a), .rvalid_o(rvalid_a), .rdata_o(rdata_a),
        .ram_en_o(en_a), .ram_we_o(rwe_a), .ram_addr_o(raddr_a), .ram_din_o(din_a),
        .ram_rst_o(rst_a), .ram_regce_o(regce_a), .ram_dout_i(dout_a)
    );

    dp_ram_port_arbiter #(
        .NUM_REQ(3), .NB_COL(4), .COL_WIDTH(8), .RAM_DEPTH(1024), .RAM_LATENCY(2), .PRIO_REQ(2)
    ) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .addr_i(addr), .we_i(we), .be_i(be),
        .wdata_i(wdata), .gnt_o(gnt_b), .rvalid_o(rvalid_b), .rdata_o(rdata_b),
        .ram_en_o(en_b), .ram_we_o(rwe_b), .ram_addr_o(raddr_b), .ram_din_o(din_b),
        .ram_rst_o(rst_b), .ram_regce_o(regce_b), .ram_dout_i(dout2_b)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                          input logic [3:0] wen);
        merge = old;
        for (int b = 0; b < 4; b++) if (wen[b]) merge[b*8 +: 8] = din[b*8 +: 8];
    endfunction

    // Write-first byte-write RAM, no output register.
    always @(posedge clk) begin
        if (load) mem_a[4] <= 32'hDEADBEEF;
        else if (en_a) begin
            mem_a[raddr_a] <= merge(mem_a[raddr_a], din_a, rwe_a);
            dout_a         <= merge(mem_a[raddr_a], din_a, rwe_a);
        end
    end

    // Write-first byte-write RAM with output register.
    always @(posedge clk) begin
        if (load) mem_b[4] <= 32'hDEADBEEF;
        else if (en_b) begin
            mem_b[raddr_b] <= merge(mem_b[raddr_b], din_b, rwe_b);
            dout1_b        <= merge(mem_b[raddr_b], din_b, rwe_b);
        end
        if (rst_b)        dout2_b <= '0;
        else if (regce_b) dout2_b <= dout1_b;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        req   = '0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests++;
            if ({gnt_a, gnt_b} !== 6'b0) begin
                fails++;
                $display("FAIL reset_gnt c%0d: got %b/%b expected 000/000", c, gnt_a, gnt_b);
            end
            tests++;
            if ({rvalid_a, rvalid_b} !== 6'b0) begin
                fails++;
                $display("FAIL reset_rvalid c%0d: got %b/%b expected 000/000", c, rvalid_a,
                         rvalid_b);
            end
            tests++;
            if ({en_a, en_b, rwe_a, rwe_b, regce_b, rst_b} !== 12'b000000000001) begin
                fails++;
                $display("FAIL reset_ram c%0d: got en %b%b we %h%h regce %b rst %b expected 0,0,1",
                         c, en_a, en_b, rwe_a, rwe_b, regce_b, rst_b);
            end
        end
        tick();
        rst_n = 1'b1;
        load  = 1'b0;
        req   = '0;
    endtask

    task automatic test_single_read();
        req = 3'b001; addr[0] = 32'h10; we = '0;
        @(negedge clk);
        tests++;
        if (gnt_a !== 3'b001 || gnt_b !== 3'b001) begin
            fails++;
            $display("FAIL read_gnt: got %b/%b expected 001/001", gnt_a, gnt_b);
        end
        tests++;
        if (en_a !== 1'b1 || raddr_a !== 10'd4 || rwe_a !== 4'b0) begin
            fails++;
            $display("FAIL read_port: got en %b addr %0d we %b expected 1 4 0000", en_a, raddr_a,
                     rwe_a);
        end
        tick(); req = '0;
        @(negedge clk);
        tests++;
        if (rvalid_a !== 3'b001 || rdata_a[0] !== 32'hDEADBEEF || rvalid_b !== 3'b000) begin
            fails++;
            $display("FAIL read_lat1: got rv %b data %h rv_b %b expected 001 deadbeef 000",
                     rvalid_a, rdata_a[0], rvalid_b);
        end
        tick();
        @(negedge clk);
        tests++;
        if (rvalid_b !== 3'b001 || rdata_b[0] !== 32'hDEADBEEF || rvalid_a !== 3'b000) begin
            fails++;
            $display("FAIL read_lat2: got rv %b data %h rv_a %b expected 001 deadbeef 000",
                     rvalid_b, rdata_b[0], rvalid_a);
        end
        tick();
    endtask

    task automatic test_byte_write();
        req = 3'b010; addr[1] = 32'h10; we = 3'b010; be[1] = 4'b0010; wdata[1] = 32'h0000AA00;
        @(negedge clk);
        tests++;
        if (gnt_a !== 3'b010 || gnt_b !== 3'b010 || rwe_a !== 4'b0010 || din_a !== 32'h0000AA00)
        begin
            fails++;
            $display("FAIL write_port: got gnt %b/%b we %b din %h expected 010/010 0010 0000aa00",
                     gnt_a, gnt_b, rwe_a, din_a);
        end
        tick(); req = '0; we = '0;
        @(negedge clk);
        tests++;
        if (rvalid_a !== 3'b010 || rdata_a[1] !== 32'hDEADAAEF) begin
            fails++;
            $display("FAIL write_rsp_a: got %b %h expected 010 deadaaef", rvalid_a, rdata_a[1]);
        end
        tick();
        @(negedge clk);
        tests++;
        if (rvalid_b !== 3'b010 || rdata_b[1] !== 32'hDEADAAEF) begin
            fails++;
            $display("FAIL write_rsp_b: got %b %h expected 010 deadaaef", rvalid_b, rdata_b[1]);
        end
        tick();
        req = 3'b001; addr[0] = 32'h10;
        tick(); req = '0;
        @(negedge clk);
        tests++;
        if (rvalid_a !== 3'b001 || rdata_a[0] !== 32'hDEADAAEF) begin
            fails++;
            $display("FAIL readback_a: got %b %h expected 001 deadaaef", rvalid_a, rdata_a[0]);
        end
        tick();
        @(negedge clk);
        tests++;
        if (rvalid_b !== 3'b001 || rdata_b[0] !== 32'hDEADAAEF) begin
            fails++;
            $display("FAIL readback_b: got %b %h expected 001 deadaaef", rvalid_b, rdata_b[0]);
        end
        tick();
    endtask

    task automatic test_alias();
        req = 3'b001; addr[0] = 32'h0000_1010; we = '0;
        @(negedge clk);
        tests++;
        if (raddr_a !== 10'd4 || raddr_b !== 10'd4) begin
            fails++;
            $display("FAIL alias_addr: got %0d/%0d expected 4/4", raddr_a, raddr_b);
        end
        tick(); req = '0;
        @(negedge clk);
        tests++;
        if (rvalid_a !== 3'b001 || rdata_a[0] !== 32'hDEADAAEF) begin
            fails++;
            $display("FAIL alias_data: got %b %h expected 001 deadaaef", rvalid_a, rdata_a[0]);
        end
        tick(); tick();
    endtask

    task automatic test_round_robin();
        logic [2:0] exp;
        pulse_reset();
        addr = {3{32'h10}}; we = '0;
        for (int c = 0; c <= 6; c++) begin
            req = (c < 6) ? 3'b111 : 3'b000;
            @(negedge clk);
            if (c < 6) begin
                exp = 3'(1 << (c % 3));
                tests++;
                if (gnt_a !== exp) begin
                    fails++;
                    $display("FAIL rr_gnt c%0d: got %b expected %b", c, gnt_a, exp);
                end
            end
            if (c >= 1) begin
                exp = 3'(1 << ((c - 1) % 3));
                tests++;
                if (rvalid_a !== exp) begin
                    fails++;
                    $display("FAIL rr_rvalid c%0d: got %b expected %b", c, rvalid_a, exp);
                end
            end
            tick();
        end
        req = '0;
    endtask

    task automatic test_priority();
        logic [2:0] rq [5];
        logic [2:0] eg [5];
        logic [2:0] ev [5];
        rq = '{3'b101, 3'b101, 3'b001, 3'b000, 3'b000};
        eg = '{3'b100, 3'b100, 3'b001, 3'b000, 3'b000};
        ev = '{3'b000, 3'b000, 3'b100, 3'b100, 3'b001};
        pulse_reset();
        addr = {3{32'h10}}; we = '0;
        for (int c = 0; c < 5; c++) begin
            req = rq[c];
            @(negedge clk);
            tests++;
            if (gnt_b !== eg[c] || rvalid_b !== ev[c]) begin
                fails++;
                $display("FAIL prio c%0d: got gnt %b rvalid %b expected %b %b", c, gnt_b,
                         rvalid_b, eg[c], ev[c]);
            end
            tick();
        end
        req = '0;
    endtask

    task automatic test_reset_midflight();
        pulse_reset();
        req = 3'b001; addr[0] = 32'h10; we = '0;
        @(negedge clk);
        tests++;
        if (gnt_b !== 3'b001) begin
            fails++;
            $display("FAIL mid_gnt: got %b expected 001", gnt_b);
        end
        tick(); req = '0; rst_n = 1'b0;
        @(negedge clk);
        tests++;
        if (rvalid_b !== 3'b000 || regce_b !== 1'b0) begin
            fails++;
            $display("FAIL mid_c1: got rvalid %b regce %b expected 000 0", rvalid_b, regce_b);
        end
        tick(); rst_n = 1'b1;
        for (int c = 2; c < 4; c++) begin
            @(negedge clk);
            tests++;
            if (rvalid_b !== 3'b000) begin
                fails++;
                $display("FAIL mid_c%0d: got rvalid %b expected 000", c, rvalid_b);
            end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0; load = 1'b1; req = 3'b111;
        addr = {3{32'h10}}; we = '0; be = '0; wdata = '0;
        test_reset();
        test_single_read();
        test_byte_write();
        test_alias();
        test_round_robin();
        test_priority();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
